regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (we / write_reg / write_data) among
//  NUM_REQ writeback requesters (e.g. ALU writeback, load writeback, multi-cycle unit).
//  Uses fixed priority (index 0 highest) with starvation escalation.
//  Registers the winning request and drives the register file one cycle later.
//  Sits between the pipeline writeback sources and the register file.
// PARAMETERS
//  DATA_W    32  width of write data
//  ADDR_W    5   width of register address
//  NUM_REQ   2   number of requesters (supported 2..4)
//  MAX_WAIT  3   consecutive stalled cycles after which a requester is escalated (>=1)
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  reset      in   1                 synchronous, active-high reset
//  req_valid  in   NUM_REQ           requester i presents a write
//  req_addr   in   NUM_REQ*ADDR_W    dest reg of requester i, bits [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W    data of requester i, bits [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ           one-hot grant; transfer when valid&ready
//  rf_we      out  1                 register-file write enable (registered)
//  rf_waddr   out  ADDR_W            register-file write address (registered)
//  rf_wdata   out  DATA_W            register-file write data (registered)
//  grant_id   out  2                 index of requester that produced current rf_* (registered)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (reset).
//  - Reset (sampled at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0,
//    all wait_cnt=0. req_ready=0 combinationally while reset is high.
//  - Per requester: wait_cnt[i] (0..MAX_WAIT, saturating).
//    valid&!ready -> +1 (saturate); valid&ready or !valid -> 0.
//  - Grant (combinational, at most one bit set):
//    a) if any valid requester has wait_cnt==MAX_WAIT, the lowest such index wins;
//    b) else the lowest valid index wins; c) no valid -> req_ready=0.
//    req_ready never asserts for a requester whose valid is low.
//  - Requester holds addr/data stable while valid&!ready; may drop valid any cycle.
//  - Latency: request accepted in cycle N -> rf_* present in cycle N+1.
//    rf_we=1 for exactly one cycle per accepted request.
//  - Cycle with no transfer -> rf_we=0 next cycle; rf_waddr/rf_wdata/grant_id hold.
//  - Register 0: request to addr 0 is accepted (ready=1, counter clears) but dropped.
//    rf_we stays 0; rf_waddr/rf_wdata/grant_id still update.
//  - Simultaneous same-address requests: serialized by grant; later write wins in RF.
//  - Back-to-back: a requester held valid is granted every cycle it wins; no bubbles.
//  - Reset mid-operation: in-flight rf_we is squashed (0 next cycle); counters cleared.
//    Arbitration restarts from plain priority once reset is low.
//  - Throughput: one write per cycle; worst-case wait for any requester is bounded
//    by (MAX_WAIT+1) * NUM_REQ cycles.
// TESTING (NUM_REQ=2, MAX_WAIT=3 unless noted)
//  1 reset high 2 cycles with req_valid=2'b11
//    -> req_ready=0 throughout; rf_we=0, rf_waddr=0, rf_wdata=0 after reset.
//  2 only req1 valid, addr=9, data=5
//    -> req_ready=2'b10 same cycle; next cycle rf_we=1, rf_waddr=9, rf_wdata=5, grant_id=1.
//  3 both valid continuously (req0 addr 8, req1 addr 10)
//    -> grants 0,0,0,1,0,0,0,1...; req1 granted in its 4th waiting cycle.
//  4 req0 valid, addr=0, data=32'hDEAD
//    -> req_ready=2'b01; next cycle rf_we=0 and rf_wdata=32'hDEAD.
//  5 both valid for 2 cycles (req1 wait_cnt=2), then reset 1 cycle, then both valid
//    -> rf_we=0 after reset; req0 wins the next 3 cycles again.
//  6 NUM_REQ=3, req1 and req2 both reach wait_cnt==MAX_WAIT while req0 valid
//    -> req1 granted first, then req2 on the following cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: fixed priority (index 0 highest) with escalation
// of requesters that have stalled MAX_WAIT cycles; the winning write is registered.
module regfile_wr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REQ  = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [1:0]                 grant_id
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(MAX_WAIT);

    logic [WCNT_W-1:0]  wait_cnt_q [NUM_REQ];
    logic [WCNT_W-1:0]  wait_cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [1:0]         win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    logic               rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic [1:0]         grant_id_q, grant_id_d;

    // Descending scan so the last hit, i.e. the lowest index, owns the grant.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_valid[i] && (wait_cnt_q[i] == WAIT_SAT);
        end
        grant = '0;
        if (!reset) begin
            if (|starved) begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (starved[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req_valid[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = 2'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !grant[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_SAT) ? WAIT_SAT
                                                            : wait_cnt_q[i] + WCNT_W'(1);
            end else begin
                wait_cnt_d[i] = '0;
            end
        end
    end

    // Writes to register 0 are consumed but never reach the register file.
    always_comb begin
        rf_we_d    = xfer && (win_addr != '0);
        rf_waddr_d = xfer ? win_addr : rf_waddr_q;
        rf_wdata_d = xfer ? win_data : rf_wdata_q;
        grant_id_d = xfer ? win_idx  : grant_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: a 2-requester vector table with a scoreboard for the
// registered rf_* outputs, plus a 3-requester escalation sequence.
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_id;

    logic        reset3;
    logic [2:0]  req_valid3;
    logic [14:0] req_addr3;
    logic [95:0] req_data3;
    logic [2:0]  req_ready3;
    logic        rf_we3;
    logic [4:0]  rf_waddr3;
    logic [31:0] rf_wdata3;
    logic [1:0]  grant_id3;

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REQ(2), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .grant_id(grant_id)
    );

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REQ(3), .MAX_WAIT(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_addr(req_addr3),
        .req_data(req_data3), .req_ready(req_ready3), .rf_we(rf_we3), .rf_waddr(rf_waddr3),
        .rf_wdata(rf_wdata3), .grant_id(grant_id3)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  gid;
    } vec_t;

    vec_t        tv[$];
    logic [39:0] sb_q[$];
    logic [7:0]  sb3_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] vld,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [1:0] rdy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [1:0] gid);
        vec_t v;
        v.rst = rst; v.vld = vld; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.gid = gid;
        tv.push_back(v);
    endtask

    initial begin
        logic [2:0] exp_rdy3 [6];
        logic [1:0] exp_gid3 [6];
        logic [4:0] exp_wa3  [6];
        logic [7:0] got3;
        logic [39:0] got;

        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        reset3 = 1'b1; req_valid3 = '0; req_addr3 = '0; req_data3 = '0;

        // rst vld  a0  d0            a1  d1            rdy  we wa  wd            gid
        add(1, 2'b11, 8, 32'h1,        10, 32'h2,        2'b00, 0, 0,  32'h0,        0);
        add(1, 2'b11, 8, 32'h1,        10, 32'h2,        2'b00, 0, 0,  32'h0,        0);
        add(0, 2'b10, 0, 32'h0,        9,  32'h5,        2'b10, 1, 9,  32'h5,        1);
        add(0, 2'b00, 0, 32'h0,        9,  32'h5,        2'b00, 0, 9,  32'h5,        1);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b10, 1, 10, 32'h200,      1);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b01, 1, 8,  32'h100,      0);
        add(0, 2'b11, 8, 32'h100,      10, 32'h200,      2'b10, 1, 10, 32'h200,      1);
        add(0, 2'b00, 8, 32'h100,      10, 32'h200,      2'b00, 0, 10, 32'h200,      1);
        add(0, 2'b01, 0, 32'hDEAD,     0,  32'h0,        2'b01, 0, 0,  32'hDEAD,     0);
        add(0, 2'b00, 0, 32'hDEAD,     0,  32'h0,        2'b00, 0, 0,  32'hDEAD,     0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b01, 1, 3,  32'h33,       0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b01, 1, 3,  32'h33,       0);
        add(1, 2'b11, 3, 32'h33,       4,  32'h44,       2'b00, 0, 0,  32'h0,        0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b01, 1, 3,  32'h33,       0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b01, 1, 3,  32'h33,       0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b01, 1, 3,  32'h33,       0);
        add(0, 2'b11, 3, 32'h33,       4,  32'h44,       2'b10, 1, 4,  32'h44,       1);
        add(0, 2'b11, 7, 32'h70,       7,  32'h71,       2'b01, 1, 7,  32'h70,       0);
        add(0, 2'b10, 7, 32'h70,       7,  32'h71,       2'b10, 1, 7,  32'h71,       1);
        add(0, 2'b00, 7, 32'h70,       7,  32'h71,       2'b00, 0, 7,  32'h71,       1);

        @(posedge clk); #1;
        for (int k = 0; k < tv.size(); k++) begin
            reset     = tv[k].rst;
            req_valid = tv[k].vld;
            req_addr  = {tv[k].a1, tv[k].a0};
            req_data  = {tv[k].d1, tv[k].d0};
            @(negedge clk);
            chk($sformatf("ready_v%0d", k), 40'(req_ready), 40'(tv[k].rdy));
            if (sb_q.size() > 0) begin
                got = {rf_we, rf_waddr, rf_wdata, grant_id};
                chk($sformatf("rf_v%0d", k - 1), got, sb_q.pop_front());
            end
            sb_q.push_back({tv[k].we, tv[k].wa, tv[k].wd, tv[k].gid});
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        got = {rf_we, rf_waddr, rf_wdata, grant_id};
        chk("rf_last", got, sb_q.pop_front());

        // Three requesters all held valid: req1 and req2 saturate together, req1 wins first.
        exp_rdy3[0] = 3'b001; exp_gid3[0] = 2'd0; exp_wa3[0] = 5'd1;
        exp_rdy3[1] = 3'b001; exp_gid3[1] = 2'd0; exp_wa3[1] = 5'd1;
        exp_rdy3[2] = 3'b001; exp_gid3[2] = 2'd0; exp_wa3[2] = 5'd1;
        exp_rdy3[3] = 3'b010; exp_gid3[3] = 2'd1; exp_wa3[3] = 5'd2;
        exp_rdy3[4] = 3'b100; exp_gid3[4] = 2'd2; exp_wa3[4] = 5'd3;
        exp_rdy3[5] = 3'b001; exp_gid3[5] = 2'd0; exp_wa3[5] = 5'd1;
        @(posedge clk); #1;
        reset3     = 1'b0;
        req_valid3 = 3'b111;
        req_addr3  = {5'd3, 5'd2, 5'd1};
        req_data3  = {32'h30, 32'h20, 32'h10};
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("ready3_c%0d", j), 40'(req_ready3), 40'(exp_rdy3[j]));
            if (sb3_q.size() > 0) begin
                got3 = {rf_we3, rf_waddr3, grant_id3};
                chk($sformatf("rf3_c%0d", j - 1), 40'(got3), 40'(sb3_q.pop_front()));
            end
            sb3_q.push_back({1'b1, exp_wa3[j], exp_gid3[j]});
            @(posedge clk); #1;
        end
        req_valid3 = '0;
        @(negedge clk);
        got3 = {rf_we3, rf_waddr3, grant_id3};
        chk("rf3_last", 40'(got3), 40'(sb3_q.pop_front()));
        chk("rf3_data", 40'(rf_wdata3), 40'(32'h10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
